// File: rtl/wide_add_pkg.sv
// Shared constants and FSM state type for the wide-adder arbiter.
package wide_add_pkg;
    localparam int SIZE_ADD   = 3072;
    localparam int ADD_BLOCK  = 512;
    localparam int ADD_SLICES = SIZE_ADD / ADD_BLOCK;
    localparam int ADD_LAT    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/wide_add_arbiter_rr.sv
// Combinational round-robin picker: first set request after ptr, with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);
    logic [IDX_W:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (req[cand[IDX_W-1:0]]) begin
                gnt                   = '0;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
                vld                   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wide_add_arbiter.sv
// Round-robin sharing of one multi-cycle wide adder among NUM_REQ requesters.
// Optional watchdog enabled by defining WIDE_ADD_ARB_TIMEOUT_EN.
module wide_add_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SIZE_ADD = 3072,
    parameter int ADD_LAT  = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SIZE_ADD-1:0]  req_a,
    input  logic [NUM_REQ*SIZE_ADD-1:0]  req_b,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [SIZE_ADD-1:0]          res,
    output logic                         busy,
    output logic [SIZE_ADD-1:0]          add_a,
    output logic [SIZE_ADD-1:0]          add_b,
    output logic                         add_en,
    input  logic [SIZE_ADD-1:0]          add_c,
    input  logic                         add_en_out,
    output logic                         err
);
    import wide_add_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || ADD_LAT < 1 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_cfg
        $error("wide_add_arbiter: unsupported parameterization");
    end

    state_t                             state, state_nxt;
    logic                               armed;
    logic [IDX_W-1:0]                   rr_ptr, owner, win_idx;
    logic [NUM_REQ-1:0]                 win_gnt;
    logic                               win_vld;
    logic [NUM_REQ-1:0][SIZE_ADD-1:0]   op_a, op_b;
    logic                               take, fin, tmo;

    assign op_a = req_a;
    assign op_b = req_b;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .vld (win_vld)
    );

    // armed keeps the combinational grant quiet while reset is held and for the release cycle.
    assign take   = (state == IDLE) && armed && win_vld;
    assign gnt    = take ? win_gnt : '0;
    assign add_en = (state == ISSUE);
    assign busy   = (state != IDLE);
    assign fin    = (state == WAIT) && add_en_out;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fin || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            armed  <= 1'b0;
            rr_ptr <= IDX_W'(NUM_REQ-1);
            owner  <= '0;
            add_a  <= '0;
            add_b  <= '0;
            res    <= '0;
            done   <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            done  <= '0;
            if (take) begin
                add_a  <= op_a[win_idx];
                add_b  <= op_b[win_idx];
                owner  <= win_idx;
                rr_ptr <= win_idx;
            end
            if (fin)
                res <= add_c;
            if (fin || tmo)
                done <= NUM_REQ'(1) << owner;
        end
    end

`ifdef WIDE_ADD_ARB_TIMEOUT_EN
    logic [3:0] wd_cnt;
    logic       err_q;

    // Counter reads 0 on the first WAIT cycle, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1.
    assign tmo = (state == WAIT) && !add_en_out && (wd_cnt == 4'(TIMEOUT-1));
    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + 4'd1 : 4'd0;
            if (tmo)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_wide_add_arbiter.sv
// Directed bench for wide_add_arbiter: agent-driven requesters, adder model, scoreboard monitor.
module tb_wide_add_arbiter;
    localparam int NUM = 4;
    localparam int SZ  = 3072;

    typedef logic [SZ-1:0] word_t;
    typedef struct {
        int    id;
        word_t res;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NUM-1:0]       req;
    logic [NUM*SZ-1:0]    req_a, req_b;
    logic [NUM-1:0]       gnt, done;
    word_t                res, add_a, add_b, add_c;
    logic                 busy, add_en, add_en_out, err;

    int    checks   = 0;
    int    failures = 0;
    exp_t  sb[$];

    word_t opa[NUM];
    word_t opb[NUM];
    int    left[NUM];
    logic [NUM-1:0] gnt_s = '0;

    wide_add_arbiter #(.NUM_REQ(NUM), .SIZE_ADD(SZ), .ADD_LAT(3), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .done       (done),
        .res        (res),
        .busy       (busy),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_en     (add_en),
        .add_c      (add_c),
        .add_en_out (add_en_out),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: add_en sampled at an edge, add_en_out high two cycles later; reset shared.
    logic [2:0] en_pipe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_pipe <= '0;
        else        en_pipe <= {en_pipe[1:0], add_en};
    end
    assign add_en_out = en_pipe[2];
    assign add_c      = add_a + add_b;

    // Requester agent: holds req while ops remain, consumes one op per observed grant.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NUM; i++) begin
            if (gnt_s[i] && left[i] > 0) left[i]--;
            req[i]             = (left[i] > 0);
            req_a[i*SZ +: SZ]  = opa[i];
            req_b[i*SZ +: SZ]  = opb[i];
        end
    end

    // Monitor / scoreboard.
    int    cyc = 0, gnt_cyc = -100;
    bit    in_op = 0, a_moved = 0, prev_en = 0;
    word_t held_a, held_b;
    exp_t  e;
    logic [NUM-1:0] exp_done;

    always @(negedge clk) begin
        cyc++;
        gnt_s = gnt;
        if (!rst_n) begin
            in_op   = 0;
            prev_en = 0;
            gnt_cyc = -100;
        end else begin
            if (in_op && (add_a != held_a || add_b != held_b)) a_moved = 1;
            if (done != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: done=%b with nothing outstanding", done);
                end else begin
                    e = sb.pop_front();
                    exp_done = '0;
                    exp_done[e.id] = 1'b1;
                    if (done !== exp_done || res !== e.res) begin
                        failures++;
                        $display("FAIL done_result: done=%b res=%h expected done=%b res=%h (low 64 bits)",
                                 done, res[63:0], exp_done, e.res[63:0]);
                    end
                end
                checks++;
                if (cyc != gnt_cyc + 5) begin
                    failures++;
                    $display("FAIL done_latency: got %0d cycles after gnt, expected 5", cyc - gnt_cyc);
                end
                checks++;
                if (a_moved) begin
                    failures++;
                    $display("FAIL operand_hold: add_a/add_b changed during operation, expected stable");
                end
                in_op = 0;
            end
            if (add_en) begin
                checks++;
                if (prev_en) begin
                    failures++;
                    $display("FAIL add_en_back_to_back: add_en high 2 cycles, expected 1");
                end
                checks++;
                if (cyc != gnt_cyc + 1) begin
                    failures++;
                    $display("FAIL add_en_latency: got %0d cycles after gnt, expected 1", cyc - gnt_cyc);
                end
                in_op   = 1;
                a_moved = 0;
                held_a  = add_a;
                held_b  = add_b;
            end
            if (gnt != '0) begin
                checks++;
                if (!$onehot(gnt)) begin
                    failures++;
                    $display("FAIL gnt_onehot: gnt=%b, expected one-hot", gnt);
                end
                gnt_cyc = cyc;
            end
            prev_en = add_en;
        end
    end

    task automatic chk(input string nm, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic issue(input int id, input word_t a, input word_t b, input int n);
        opa[id]  = a;
        opb[id]  = b;
        left[id] = n;
    endtask

    task automatic expect_res(input int id, input word_t r);
        exp_t x;
        x.id  = id;
        x.res = r;
        sb.push_back(x);
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < NUM; i++) p += left[i];
        return p;
    endfunction

    task automatic drain(input string nm);
        bit ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk);
            #3;
            if (sb.size() == 0 && !busy && pending() == 0) ok = 1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0 within 200 cycles", nm, sb.size());
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_gnt"},    word_t'(gnt),    '0);
        chk({nm, "_done"},   word_t'(done),   '0);
        chk({nm, "_res"},    res,             '0);
        chk({nm, "_busy"},   word_t'(busy),   '0);
        chk({nm, "_add_a"},  add_a,           '0);
        chk({nm, "_add_b"},  add_b,           '0);
        chk({nm, "_add_en"}, word_t'(add_en), '0);
        chk({nm, "_err"},    word_t'(err),    '0);
    endtask

    word_t ones, one, half;
    bit    seen;

    initial begin
        ones = '1;
        one  = word_t'(1);
        half = one << 1535;
        for (int i = 0; i < NUM; i++) begin
            opa[i]  = '0;
            opb[i]  = '0;
            left[i] = 0;
        end
        req   = '0;
        req_a = '0;
        req_b = '0;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // All four requesting from reset: order 0,1,2,3,0.
        issue(0, word_t'(100), word_t'(1), 2);
        issue(1, word_t'(200), word_t'(2), 1);
        issue(2, word_t'(300), word_t'(3), 1);
        issue(3, word_t'(400), word_t'(4), 1);
        expect_res(0, word_t'(101));
        expect_res(1, word_t'(202));
        expect_res(2, word_t'(303));
        expect_res(3, word_t'(404));
        expect_res(0, word_t'(101));
        drain("rr_all");

        // Single request, carry-out dropped.
        @(posedge clk); #1;
        issue(0, one, ones, 1);
        expect_res(0, '0);
        drain("single");

        // Two together: lower index after pointer wins first.
        @(posedge clk); #1;
        issue(1, word_t'(5), word_t'(7), 1);
        issue(2, word_t'(9), word_t'(9), 1);
        expect_res(1, word_t'(12));
        expect_res(2, word_t'(18));
        drain("pair");

        // Full carry ripple, then a carry across the middle slice boundary.
        @(posedge clk); #1;
        issue(3, ones, one, 1);
        expect_res(3, '0);
        drain("carry_all");
        @(posedge clk); #1;
        issue(3, half, half, 1);
        expect_res(3, one << 1536);
        drain("carry_mid");

        // Reset two cycles into an operation: no done for it.
        @(posedge clk); #1;
        issue(0, word_t'(1), word_t'(1), 1);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk); #1;
            if (gnt != '0) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_gnt: no grant within 50 cycles, expected one");
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_busy_before", word_t'(busy), word_t'(1));
        rst_n = 1'b0;
        for (int i = 0; i < NUM; i++) left[i] = 0;
        #1;
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(2, word_t'(123), word_t'(456), 1);
        expect_res(2, word_t'(579));
        drain("after_reset");

        repeat (8) @(posedge clk);
        #1;
        chk("err_final", word_t'(err), '0);
        chk("sb_empty", word_t'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wide_add_arbiter.md
Name: wide_add_arbiter

Overview:
- Shares one 3072-bit multi-cycle carry-select adder (6 x 512-bit slices, en -> en_out latency 3 cycles) among NUM_REQ requesters, e.g. the Montgomery reduction and modexp accumulate stages.
- Arbitrates round-robin and latches the winner's operands.
- Holds the operands stable for the whole adder operation, pulses the adder start, and returns the sum to the winner with a one-cycle done strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIZE_ADD, 3072, operand/result width in bits.
- ADD_LAT, 3, cycles from the clock edge that samples add_en to the first cycle add_en_out is high.
- TIMEOUT, 15, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low; also drives the adder's rst_n.
- req  in  NUM_REQ  per-requester request level.
- req_a  in  NUM_REQ*SIZE_ADD  operand A; slice i = req_a[i*SIZE_ADD +: SIZE_ADD].
- req_b  in  NUM_REQ*SIZE_ADD  operand B, same packing.
- gnt  out  NUM_REQ  one-hot grant pulse; operands captured on this cycle.
- done  out  NUM_REQ  one-hot result-valid pulse.
- res  out  SIZE_ADD  sum (mod 2^SIZE_ADD, carry-out dropped); held until the next result.
- busy  out  1  high whenever state != IDLE.
- add_a, add_b  out  SIZE_ADD  operands to the adder, registered.
- add_en  out  1  adder start pulse.
- add_c  in  SIZE_ADD  adder result.
- add_en_out  in  1  adder result-valid pulse.
- err  out  1  sticky watchdog error (optional feature; tied 0 otherwise).

Behaviour:
- One clock. Reset is asynchronous and active-low; all registers clear immediately on rst_n low.
- Reset values:
  - gnt=0, done=0, res=0, busy=0, add_a=0, add_b=0, add_en=0, err=0.
  - state=IDLE, owner=0.
  - rr_ptr=NUM_REQ-1, so req[0] has top priority first.
- Requester protocol:
  - Raise req[i] with req_a/req_b stable and hold them until gnt[i].
  - Drop req[i] in the cycle after gnt, or keep it high to queue a new operation that is sampled only after done[i].
  - req[i] high while that requester's own operation is outstanding is ignored until done[i].
- FSM IDLE:
  - If any req is high, choose the first set bit scanning from rr_ptr+1 with wrap-around.
  - Register add_a/add_b from that slice, set owner and rr_ptr to the winner, pulse gnt[winner] one cycle, go to ISSUE.
  - With no req, stay in IDLE.
- FSM ISSUE: add_en=1 for exactly this one cycle; go to WAIT.
- FSM WAIT:
  - add_a/add_b must not change; the adder reads them combinationally over two cycles.
  - On add_en_out: res <= add_c, done[owner] pulses the following cycle, go to IDLE.
- Timing: gnt at cycle T, add_en at T+1, add_en_out at T+4, done/res valid at T+5. The next gnt is possible at T+5, so maximum throughput is one operation per 5 cycles.
- add_en is never high in two consecutive cycles and never high while state is WAIT; this protects the adder's flag sequencing.
- add_en_out seen in IDLE or ISSUE is spurious and ignored, with no done.
- Simultaneous requests: strict round-robin. With all four requesters continuously requesting after reset, grant order is 0,1,2,3,0,...
- A newly arriving req cannot preempt an operation already in progress.
- Reset mid-operation: the FSM returns to IDLE immediately and no done is issued for the aborted operation. The adder resets on the same net.

Optional Feature:
- Macro WIDE_ADD_ARB_TIMEOUT_EN.
- When defined:
  - A 4-bit counter starts at 0 on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without add_en_out: set err (sticky until reset), pulse done[owner] with res unchanged, return to IDLE.
- When undefined: no counter, err is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package wide_add_pkg: SIZE_ADD, ADD_BLOCK=512, ADD_SLICES=6, ADD_LAT=3, and the state enum IDLE/ISSUE/WAIT.
- One sub-module, rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant plus index out, combinational.
- The FSM, operand/result registers and watchdog live in the top module.

Test Plan:
- req=4'b0001, A=1, B=2^3072-1 -> gnt[0] at T, add_en at T+1, done[0] at T+5, res=0 (carry dropped).
- req=4'b0110 asserted together -> gnt[1] first, then gnt[2] 5 cycles later; res values 5+7=12 and 9+9=18 routed to the correct done bits.
- req=4'b1111 held with distinct operands -> grant order 0,1,2,3,0; no add_en in two consecutive cycles; add_a stable throughout every WAIT.
- Carry chain across all slices: A=2^512-1 in every slice (all ones), B=1 -> res=0. Then A=2^1535, B=2^1535 -> res=2^1536.
- rst_n low at T+2 of an operation -> all outputs 0 immediately, no done; a new req after release completes correctly.
- With WIDE_ADD_ARB_TIMEOUT_EN and add_en_out forced low -> done[owner] and err=1 after TIMEOUT WAIT cycles; err stays 1 until reset.
